// File: rtl/detector_de_sequencia_gen_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package detector_de_sequencia_gen_pkg;

    localparam int SEQ_LEN_MIN = 1;
    localparam int SEQ_LEN_MAX = 16;

    // Width of a counter that must hold the values 0..len inclusive.
    function automatic int fill_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/detector_de_sequencia_gen_hist.sv
// History shift register plus saturating fill counter.
// Presents the window and fill status as they will be after the current edge.
module seq_hist_shift
    import detector_de_sequencia_gen_pkg::*;
#(
    parameter int SEQ_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    output logic [SEQ_LEN-1:0] hist_next,
    output logic               full_next
);

    localparam int FW = fill_width(SEQ_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(SEQ_LEN);

    logic [FW-1:0] fill;
    logic [FW-1:0] fill_next;

    always_comb begin
        fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
        full_next = (fill_next == FILL_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill <= '0;
        end else begin
            fill <= fill_next;
        end
    end

    // The oldest window bit is shifted out on the next edge, so only the
    // younger SEQ_LEN-1 bits need storage.
    generate
        if (SEQ_LEN == 1) begin : g_single
            assign hist_next = in;
        end else begin : g_multi
            logic [SEQ_LEN-2:0] hist;

            assign hist_next = {hist, in};

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    hist <= '0;
                end else begin
                    hist <= hist_next[SEQ_LEN-2:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/detector_de_sequencia_gen.sv
// Serial pattern detector: registered one-cycle flag when the last SEQ_LEN
// received bits equal seq (oldest bit in seq[SEQ_LEN-1]); overlaps allowed.
module detector_de_sequencia_gen
    import detector_de_sequencia_gen_pkg::*;
#(
    parameter int SEQ_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic [SEQ_LEN-1:0] seq,
    output logic               s
);

    logic [SEQ_LEN-1:0] hist_next;
    logic               full_next;

    seq_hist_shift #(
        .SEQ_LEN (SEQ_LEN)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .hist_next (hist_next),
        .full_next (full_next)
    );

    // Fill guard keeps the zeroed history from matching an all-zero pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s <= 1'b0;
        end else begin
            s <= full_next && (hist_next == seq);
        end
    end

endmodule

// File: tb/tb_detector_de_sequencia_gen.sv
// Bench for detector_de_sequencia_gen: directed scenarios then random traffic
// against a queue-based model of the received bit stream.
module tb_detector_de_sequencia_gen;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in;
    logic [W-1:0] seq;
    logic         s;

    int n_checks = 0;
    int n_fail   = 0;

    bit           rx_q[$];   // bits received since the last reset, oldest first
    logic [0:0]   exp_q[$];  // expected s values awaiting comparison

    detector_de_sequencia_gen #(
        .SEQ_LEN (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .seq (seq),
        .s   (s)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed s=%b expected s=%b", tag, obs, exp);
        end
    endtask

    // Reference: a match exists when at least W bits have arrived since reset
    // and the newest W of them, read oldest to newest, spell seq MSB to LSB.
    function automatic logic model_match(input logic [W-1:0] pat);
        if (rx_q.size() < W) return 1'b0;
        for (int k = 0; k < W; k++) begin
            if (rx_q[rx_q.size() - W + k] != pat[W-1-k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive one bit, let the edge sample it, then compare s just after the edge.
    task automatic step(input logic b, input string tag);
        in = b;
        @(posedge clk);
        rx_q.push_back(b);
        if (rx_q.size() > 2 * W) void'(rx_q.pop_front());
        exp_q.push_back(model_match(seq));
        #1;
        check(tag, s, exp_q.pop_front());
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n, input string tag);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(v[i], tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        rx_q.delete();
        #1;
        check(tag, s, 1'b0);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        in  = 1'b0;
        seq = 4'b0110;

        // 1. reset hold with in toggling, then a first match
        for (int i = 0; i < 3; i++) begin
            in = ~in;
            @(posedge clk);
            #1;
            check("reset_hold", s, 1'b0);
        end
        rst = 1'b1;
        drive_bits(16'b0110, 4, "first_match");
        step(1'b1, "first_match_drop");

        // 2. overlap
        async_reset("t2_reset");
        seq = 4'b0110;
        drive_bits(16'b01101100, 8, "overlap");

        // 3. all-zero guard
        async_reset("t3_reset");
        seq = 4'b0000;
        drive_bits(16'b00000, 5, "zero_guard");

        // 4. async reset mid-stream
        async_reset("t4_reset");
        seq = 4'b0110;
        drive_bits(16'b011, 3, "mid_pre");
        async_reset("mid_reset");
        step(1'b0, "mid_post0");
        drive_bits(16'b0110, 4, "mid_refill");

        // 5. pattern change with history retained
        seq = 4'b1101;
        step(1'b1, "seq_change_hit");
        seq = 4'b0000;
        step(1'b0, "seq_change_miss");

        // 6. non-matching stream then a hit
        async_reset("t6_reset");
        seq = 4'b1111;
        drive_bits(16'b11101110, 8, "nomatch");
        drive_bits(16'b1111, 4, "ones_hit");

        // random traffic, seq changes and occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) seq = W'($urandom_range(0, (1 << W) - 1));
            if ($urandom_range(0, 63) == 0) async_reset("rand_reset");
            step(($urandom_range(0, 3) == 0) ? 1'b0 : seq[$urandom_range(0, W - 1)], "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
